vga_write_arbiter: RTL and testbench
====================================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 160, screen width in pixels.
REQ-002 Parameter HEIGHT, default 120, screen height in pixels.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clear_req  input  1  request full-screen fill with black (colour 3'b000).
REQ-006 splash_req  input  1  splash/title renderer requests one pixel write.
REQ-007 splash_x  input  8, splash_y  input  7, splash_color  input  3  splash pixel data.
REQ-008 splash_gnt  output  1  splash pixel accepted this cycle (combinational).
REQ-009 game_req  input  1  snake/food renderer requests one pixel write.
REQ-010 game_x  input  8, game_y  input  7, game_color  input  3  game pixel data.
REQ-011 game_gnt  output  1  game pixel accepted this cycle (combinational).
REQ-012 vga_x  output  8, vga_y  output  7, vga_color  output  3  registered VGA adapter write port.
REQ-013 vga_plot  output  1  registered write enable to VGA adapter.
REQ-014 clear_busy  output  1  high while the sweep is running.
REQ-015 clear_done  output  1  registered one-cycle pulse at sweep completion.
REQ-016 oob_err  output  1  sticky flag: a granted pixel had out-of-range coordinates.

Function
REQ-017 The state machine SHALL have two states, IDLE and CLEAR; clear_busy SHALL equal (state==CLEAR).
REQ-018 IDLE -> CLEAR when clear_req is sampled high; the sweep counters (x_cnt, y_cnt) SHALL load 0,0 on that edge.
REQ-019 In CLEAR, each cycle SHALL register (x_cnt, y_cnt, 3'b000) onto vga_x/vga_y/vga_color with vga_plot=1 at the next edge.
REQ-020 x_cnt SHALL increment 0..WIDTH-1, then wrap to 0 with y_cnt+1; the sweep covers exactly WIDTH*HEIGHT pixels in raster order with no gaps.
REQ-021 On the edge that registers pixel (WIDTH-1, HEIGHT-1), state SHALL return to IDLE and clear_done SHALL be 1 for that one cycle only.
REQ-022 clear_req sampled high while in CLEAR SHALL restart the sweep at (0,0); clear_done SHALL NOT pulse for the abandoned sweep.
REQ-023 In CLEAR, splash_gnt and game_gnt SHALL be 0 regardless of requests.
REQ-024 In IDLE with clear_req high, clear SHALL win: no grant issued that cycle.
REQ-025 In IDLE with clear_req low, at most one grant SHALL be asserted per cycle; a lone requester SHALL be granted every cycle it requests (back-to-back).
REQ-026 When both splash_req and game_req are high, grant SHALL go to the requester not granted most recently (round-robin); the last-winner pointer updates only on a grant.
REQ-027 A granted pixel SHALL appear on vga_x/vga_y/vga_color with vga_plot=1 at the next edge (one-cycle latency); requester may change data the cycle after its grant.
REQ-028 A requester SHALL hold req and data stable until granted; the arbiter SHALL not buffer ungranted requests.
REQ-029 A granted pixel with x>=WIDTH or y>=HEIGHT SHALL be consumed (grant asserted) but vga_plot SHALL be 0 next cycle and oob_err SHALL set and stay 1 until reset.
REQ-030 In cycles with no grant and no sweep pixel, vga_plot SHALL be 0; vga_x/vga_y/vga_color SHALL hold their last values.

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE, x_cnt=y_cnt=0, vga_x=vga_y=vga_color=0, vga_plot=0, clear_done=0, oob_err=0, last-winner pointer=game (so splash wins the first tie).
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep; after release, no sweep pixel and no clear_done SHALL be produced without a new clear_req.

Verification
REQ-033 Reset, single-cycle clear_req, WIDTH=160,HEIGHT=120 -> vga_plot high 19200 consecutive cycles, first (0,0), 161st (0,1), last (159,119) black; clear_done one pulse coincident with last pixel; clear_busy low afterwards.
REQ-034 splash_req and game_req held high for 4 cycles after reset -> grants splash, game, splash, game; vga outputs follow one cycle later with matching data.
REQ-035 game_req high during sweep, sweep completes -> game_gnt 0 throughout CLEAR, 1 in first IDLE cycle; pixel plotted next cycle.
REQ-036 clear_req re-pulsed at sweep pixel 5000 -> next plotted pixel (0,0), total 5000+19200 plots, exactly one clear_done.
REQ-037 splash pixel (160,10) granted -> vga_plot 0 next cycle, oob_err 1 and sticky until rst.
REQ-038 rst pulsed low at sweep pixel 100 -> all outputs 0 immediately, no further plots or clear_done after release.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// VGA framebuffer write arbiter.
// Merges pixel writes from a splash renderer and a game renderer onto one
// registered VGA adapter write port. A full-screen clear sweep has priority.
// A tie between the two renderers is resolved round-robin. A granted pixel
// with off-screen coordinates is consumed and not plotted, and it sets a
// sticky error flag.
module vga_write_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_req,
  input  logic       splash_req,
  input  logic [7:0] splash_x,
  input  logic [6:0] splash_y,
  input  logic [2:0] splash_color,
  output logic       splash_gnt,
  input  logic       game_req,
  input  logic [7:0] game_x,
  input  logic [6:0] game_y,
  input  logic [2:0] game_color,
  output logic       game_gnt,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       clear_busy,
  output logic       clear_done,
  output logic       oob_err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // The sweep ends at the last column of the last row.
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);
  localparam logic [8:0] X_LIM  = 9'(WIDTH);
  localparam logic [7:0] Y_LIM  = 8'(HEIGHT);

  state_t     state_r;
  logic [7:0] x_cnt_r;
  logic [6:0] y_cnt_r;
  // High when the game renderer won the most recent grant.
  logic       last_game_r;

  logic       gnt_any_s;
  logic [7:0] px_x_s;
  logic [6:0] px_y_s;
  logic [2:0] px_color_s;
  logic       px_ok_s;

  // Returns 1 when the pixel lies on the visible screen.
  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  endfunction

  assign clear_busy = (state_r == ST_CLEAR);

  // Grant decision: only in IDLE when no clear is requested. A tie goes to
  // the requester that did not win last time.
  always_comb begin
    splash_gnt = 1'b0;
    game_gnt   = 1'b0;
    if ((state_r == ST_IDLE) && !clear_req) begin
      if (splash_req && game_req) begin
        if (last_game_r) begin
          splash_gnt = 1'b1;
        end else begin
          game_gnt = 1'b1;
        end
      end else if (splash_req) begin
        splash_gnt = 1'b1;
      end else if (game_req) begin
        game_gnt = 1'b1;
      end else begin
        splash_gnt = 1'b0;
        game_gnt   = 1'b0;
      end
    end else begin
      splash_gnt = 1'b0;
      game_gnt   = 1'b0;
    end
  end

  // Select the pixel data of whichever requester was granted.
  always_comb begin
    gnt_any_s = splash_gnt | game_gnt;
    if (game_gnt) begin
      px_x_s     = game_x;
      px_y_s     = game_y;
      px_color_s = game_color;
    end else begin
      px_x_s     = splash_x;
      px_y_s     = splash_y;
      px_color_s = splash_color;
    end
    px_ok_s = on_screen(px_x_s, px_y_s);
  end

  // Control FSM: runs the clear sweep, forwards granted pixels, keeps the
  // round-robin pointer and the sticky error flag, and registers every output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      x_cnt_r     <= 8'd0;
      y_cnt_r     <= 7'd0;
      last_game_r <= 1'b1;
      vga_x       <= 8'd0;
      vga_y       <= 7'd0;
      vga_color   <= 3'd0;
      vga_plot    <= 1'b0;
      clear_done  <= 1'b0;
      oob_err     <= 1'b0;
    end else begin
      vga_plot   <= 1'b0;
      clear_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (clear_req) begin
            state_r <= ST_CLEAR;
            x_cnt_r <= 8'd0;
            y_cnt_r <= 7'd0;
          end else if (gnt_any_s) begin
            last_game_r <= game_gnt;
            if (px_ok_s) begin
              vga_x     <= px_x_s;
              vga_y     <= px_y_s;
              vga_color <= px_color_s;
              vga_plot  <= 1'b1;
            end else begin
              // Off-screen pixel: consumed, write port holds its data.
              oob_err <= 1'b1;
            end
          end else begin
            vga_plot <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clear_req) begin
            // Restart: the abandoned sweep never reports completion.
            x_cnt_r <= 8'd0;
            y_cnt_r <= 7'd0;
          end else begin
            vga_x     <= x_cnt_r;
            vga_y     <= y_cnt_r;
            vga_color <= 3'd0;
            vga_plot  <= 1'b1;
            if (x_cnt_r == X_LAST) begin
              x_cnt_r <= 8'd0;
              if (y_cnt_r == Y_LAST) begin
                y_cnt_r    <= 7'd0;
                state_r    <= ST_IDLE;
                clear_done <= 1'b1;
              end else begin
                y_cnt_r <= y_cnt_r + 7'd1;
              end
            end else begin
              x_cnt_r <= x_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter. A behavioural model tracks the
// sweep as a linear pixel index and the arbiter as a "who won last" bit. The
// bench compares the DUT against that model on every cycle. Directed
// scenarios add literal expectations.
module tb_vga_write_arbiter;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk;
  logic       rst;
  logic       clear_req;
  logic       splash_req;
  logic [7:0] splash_x;
  logic [6:0] splash_y;
  logic [2:0] splash_color;
  logic       splash_gnt;
  logic       game_req;
  logic [7:0] game_x;
  logic [6:0] game_y;
  logic [2:0] game_color;
  logic       game_gnt;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_plot;
  logic       clear_busy;
  logic       clear_done;
  logic       oob_err;

  vga_write_arbiter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .splash_req   (splash_req),
    .splash_x     (splash_x),
    .splash_y     (splash_y),
    .splash_color (splash_color),
    .splash_gnt   (splash_gnt),
    .game_req     (game_req),
    .game_x       (game_x),
    .game_y       (game_y),
    .game_color   (game_color),
    .game_gnt     (game_gnt),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_color    (vga_color),
    .vga_plot     (vga_plot),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .oob_err      (oob_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  bit         m_busy;
  int         m_idx;        // linear raster index of the next sweep pixel
  bit         m_last_game;  // the game renderer won the latest grant
  bit         m_plot;
  bit         m_done;
  bit         m_oob;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;

  bit s_gnt_seen;
  bit g_gnt_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_idx = 0; m_last_game = 1'b1;
    m_plot = 1'b0; m_done = 1'b0; m_oob = 1'b0;
    m_x = 8'd0; m_y = 7'd0; m_c = 3'd0;
  endtask

  // Expected grants: none while sweeping or while a clear is asked for.
  // A contested cycle goes to whoever did not win last time.
  task automatic model_gnt(output bit es, output bit eg);
    es = 1'b0; eg = 1'b0;
    if (!m_busy && !clear_req) begin
      if (splash_req && game_req) begin
        es = m_last_game;
        eg = !m_last_game;
      end else begin
        es = splash_req;
        eg = game_req;
      end
    end
  endtask

  task automatic model_edge(input bit es, input bit eg);
    int px, py;
    m_done = 1'b0;
    m_plot = 1'b0;
    if (clear_req) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (m_busy) begin
      m_x = 8'(m_idx % W);
      m_y = 7'(m_idx / W);
      m_c = 3'd0;
      m_plot = 1'b1;
      m_idx++;
      if (m_idx == W * H) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (es || eg) begin
      px = eg ? int'(game_x) : int'(splash_x);
      py = eg ? int'(game_y) : int'(splash_y);
      if (px < W && py < H) begin
        m_x = 8'(px);
        m_y = 7'(py);
        m_c = eg ? game_color : splash_color;
        m_plot = 1'b1;
      end else begin
        m_oob = 1'b1;
      end
      m_last_game = eg;
    end
  endtask

  // One clock cycle. Inputs are already driven. First check the grants, then
  // apply the edge and check the registered outputs. Returns at the next
  // falling edge.
  task automatic step();
    bit es, eg;
    #1;
    model_gnt(es, eg);
    chk("splash_gnt", int'(splash_gnt), int'(es));
    chk("game_gnt", int'(game_gnt), int'(eg));
    s_gnt_seen = splash_gnt;
    g_gnt_seen = game_gnt;
    @(posedge clk);
    model_edge(es, eg);
    #1;
    chk("vga_plot", int'(vga_plot), int'(m_plot));
    chk("vga_x", int'(vga_x), int'(m_x));
    chk("vga_y", int'(vga_y), int'(m_y));
    chk("vga_color", int'(vga_color), int'(m_c));
    chk("clear_done", int'(clear_done), int'(m_done));
    chk("clear_busy", int'(clear_busy), int'(m_busy));
    chk("oob_err", int'(oob_err), int'(m_oob));
    @(negedge clk);
  endtask

  // Async reset, asserted away from any rising edge, with immediate checks.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    clear_req = 1'b0; splash_req = 1'b0; game_req = 1'b0;
    #1;
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_vga_color", int'(vga_color), 0);
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_clear_busy", int'(clear_busy), 0);
    chk("rst_oob_err", int'(oob_err), 0);
    model_reset();
    s_gnt_seen = 1'b0; g_gnt_seen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Random renderers. A pending request and its data are held until granted.
  task automatic rand_traffic();
    if (!(splash_req && !s_gnt_seen)) begin
      splash_req   = ($urandom_range(0, 2) != 0);
      splash_x     = 8'($urandom_range(0, W - 1));
      splash_y     = 7'($urandom_range(0, H - 1));
      splash_color = 3'($urandom_range(0, 7));
    end
    if (!(game_req && !g_gnt_seen)) begin
      game_req   = ($urandom_range(0, 2) != 0);
      game_x     = 8'($urandom_range(0, W - 1));
      game_y     = 7'($urandom_range(0, H - 1));
      game_color = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int plots, dones, gaps, gnt_in_clear;
    bit got_done;
    rst = 1'b1;
    clear_req = 1'b0; splash_req = 1'b0; game_req = 1'b0;
    splash_x = 8'd0; splash_y = 7'd0; splash_color = 3'd0;
    game_x = 8'd0; game_y = 7'd0; game_color = 3'd0;
    model_reset();
    do_reset();

    // Round-robin tie after reset: splash, game, splash, game.
    splash_req = 1'b1; splash_x = 8'd1; splash_y = 7'd2; splash_color = 3'd1;
    game_req   = 1'b1; game_x   = 8'd4; game_y   = 7'd5; game_color   = 3'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_splash_gnt", int'(s_gnt_seen), (k % 2 == 0) ? 1 : 0);
      chk("rr_game_gnt", int'(g_gnt_seen), (k % 2 == 0) ? 0 : 1);
      chk("rr_vga_x", int'(vga_x), (k % 2 == 0) ? 1 : 4);
      chk("rr_vga_color", int'(vga_color), (k % 2 == 0) ? 1 : 2);
      chk("rr_vga_plot", int'(vga_plot), 1);
    end
    splash_req = 1'b0; game_req = 1'b0;
    step();
    chk("idle_no_plot", int'(vga_plot), 0);
    chk("idle_hold_x", int'(vga_x), 4);

    // Random on-screen traffic without clears.
    for (int i = 0; i < 2000; i++) begin
      rand_traffic();
      step();
    end

    // Full sweep with the game renderer waiting throughout.
    splash_req = 1'b0;
    game_req = 1'b1; game_x = 8'd20; game_y = 7'd30; game_color = 3'd6;
    clear_req = 1'b1;
    step();
    chk("clear_wins_tie", int'(g_gnt_seen), 0);
    clear_req = 1'b0;
    plots = 0; dones = 0; gaps = 0; gnt_in_clear = 0; got_done = 1'b0;
    for (int i = 0; i < 19300 && !got_done; i++) begin
      step();
      if (g_gnt_seen) gnt_in_clear++;
      if (vga_plot) begin
        plots++;
        if (plots == 1) begin
          chk("sweep_first_x", int'(vga_x), 0);
          chk("sweep_first_y", int'(vga_y), 0);
        end
        if (plots == 161) begin
          chk("sweep_161_x", int'(vga_x), 0);
          chk("sweep_161_y", int'(vga_y), 1);
        end
      end else if (plots > 0) begin
        gaps++;
      end
      if (clear_done) begin
        got_done = 1'b1;
        chk("sweep_plots", plots, 19200);
        chk("sweep_last_x", int'(vga_x), 159);
        chk("sweep_last_y", int'(vga_y), 119);
        chk("sweep_last_color", int'(vga_color), 0);
      end
    end
    chk("sweep_completed", int'(got_done), 1);
    chk("sweep_gaps", gaps, 0);
    chk("game_gnt_in_clear", gnt_in_clear, 0);
    step();
    chk("game_gnt_first_idle", int'(g_gnt_seen), 1);
    chk("game_plot_after_clear", int'(vga_plot), 1);
    chk("game_x_after_clear", int'(vga_x), 20);
    chk("game_y_after_clear", int'(vga_y), 30);
    chk("busy_after_clear", int'(clear_busy), 0);
    game_req = 1'b0;
    step();
    chk("done_single_pulse", int'(clear_done), 0);

    // Restart the sweep after 5000 plotted pixels.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    plots = 0; dones = 0; got_done = 1'b0;
    for (int i = 0; i < 5100 && plots < 5000; i++) begin
      step();
      if (vga_plot) plots++;
      if (clear_done) dones++;
    end
    clear_req = 1'b1;
    step();
    if (vga_plot) plots++;
    if (clear_done) dones++;
    clear_req = 1'b0;
    for (int i = 0; i < 19300 && !got_done; i++) begin
      step();
      if (vga_plot) begin
        plots++;
        if (plots == 5001) begin
          chk("restart_first_x", int'(vga_x), 0);
          chk("restart_first_y", int'(vga_y), 0);
        end
      end
      if (clear_done) begin
        dones++;
        got_done = 1'b1;
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (vga_plot) plots++;
      if (clear_done) dones++;
    end
    chk("restart_total_plots", plots, 5000 + 19200);
    chk("restart_done_count", dones, 1);

    // Reset in the middle of a sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    plots = 0;
    for (int i = 0; i < 200 && plots < 100; i++) begin
      step();
      if (vga_plot) plots++;
    end
    chk("pre_reset_plots", plots, 100);
    do_reset();
    plots = 0; dones = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (vga_plot) plots++;
      if (clear_done) dones++;
    end
    chk("post_reset_plots", plots, 0);
    chk("post_reset_dones", dones, 0);

    // Off-screen splash pixel is consumed, not plotted, and sets a sticky flag.
    splash_req = 1'b1; splash_x = 8'd160; splash_y = 7'd10; splash_color = 3'd5;
    game_req = 1'b0;
    step();
    chk("oob_granted", int'(s_gnt_seen), 1);
    chk("oob_no_plot", int'(vga_plot), 0);
    chk("oob_set", int'(oob_err), 1);
    chk("oob_hold_x", int'(vga_x), 0);
    splash_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rand_traffic();
      step();
    end
    chk("oob_sticky", int'(oob_err), 1);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
